mem_miss_responder: RTL and testbench

- Main-memory side of the cache-miss protocol used by the dual-issue MIPS pipeline.
- Accepts three request types from the L1 caches: instruction read miss (ireadmiss), data read miss (readmiss) and write-through store (writemiss).
- Models fixed DRAM latency against a backing memory port, streams refill words to the requesting cache, and returns one-cycle iReadReady, ReadReady and WriteReady pulses. The pipeline hazard unit uses these pulses to release its IMEM/DMEM stalls.

---
 rtl/mem_miss_responder.sv | 192 +++++++++++++++++++
 tb/tb_mem_miss_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_miss_responder.sv
// Main-memory responder for I/D cache misses and write-through stores: one transaction at a time,
// fixed access latency, block refill bursts, and single-cycle Ready pulses back to the pipeline.
module mem_miss_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int MEM_LATENCY = 4,
  localparam int IDX_W      = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ireadmiss,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              abort,
  input  logic              readmiss,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              writemiss,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_valid,
  output logic              fill_target,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              iReadReady,
  output logic              ReadReady,
  output logic              WriteReady,
  output logic              busy
);

  localparam int MAX_CNT = (MEM_LATENCY > BLOCK_WORDS) ? MEM_LATENCY : BLOCK_WORDS;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(BLOCK_WORDS * 4 - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BURST, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {T_I, T_D, T_W} req_t;

  state_t            state, state_n;
  req_t              cur_type, type_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] cur_addr, addr_n;
  logic [DATA_W-1:0] cur_wdata, wd_n;

  logic              ireq_q, rreq_q, wreq_q;
  logic              pend_i, pend_d, pend_w;
  logic              pi_n, pd_n, pw_n;
  logic [ADDR_W-1:0] iaddr_q, raddr_q, waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              rise_i, rise_d, rise_w;
  logic              pi, pd, pw;
  logic [ADDR_W-1:0] ia, ra, wa;
  logic [DATA_W-1:0] wd;
  logic              i_kill, can_arb;

  // A rise on this edge counts as pending immediately so arbitration can pick it up the same edge.
  always_comb begin
    rise_i  = ireadmiss & ~ireq_q & ~abort;
    rise_d  = readmiss & ~rreq_q;
    rise_w  = writemiss & ~wreq_q;
    pi      = (pend_i | rise_i) & ~abort;
    pd      = pend_d | rise_d;
    pw      = pend_w | rise_w;
    ia      = rise_i ? iaddr : iaddr_q;
    ra      = rise_d ? raddr : raddr_q;
    wa      = rise_w ? waddr : waddr_q;
    wd      = rise_w ? wdata : wdata_q;
    i_kill  = abort && (cur_type == T_I) &&
              (state == S_WAIT || state == S_BURST || state == S_DONE);
    can_arb = (state == S_IDLE) || (state == S_DONE && !i_kill);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    type_n  = cur_type;
    addr_n  = cur_addr;
    wd_n    = cur_wdata;
    pi_n    = pi;
    pd_n    = pd;
    pw_n    = pw;
    case (state)
      S_WAIT: begin
        if (cnt == CNT_W'(MEM_LATENCY - 1)) begin
          cnt_n   = '0;
          state_n = (cur_type == T_W) ? S_WRITE : S_BURST;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_BURST: begin
        if (cnt == CNT_W'(BLOCK_WORDS - 1)) begin
          cnt_n   = '0;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_WRITE: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    if (can_arb) begin
      if (pw) begin
        state_n = S_WAIT;
        cnt_n   = '0;
        type_n  = T_W;
        addr_n  = wa;
        wd_n    = wd;
        pw_n    = 1'b0;
      end else if (pd) begin
        state_n = S_WAIT;
        cnt_n   = '0;
        type_n  = T_D;
        addr_n  = ra;
        pd_n    = 1'b0;
      end else if (pi) begin
        state_n = S_WAIT;
        cnt_n   = '0;
        type_n  = T_I;
        addr_n  = ia;
        pi_n    = 1'b0;
      end
    end
    if (i_kill) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_type  <= T_I;
      cnt       <= '0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      ireq_q    <= 1'b0;
      rreq_q    <= 1'b0;
      wreq_q    <= 1'b0;
      pend_i    <= 1'b0;
      pend_d    <= 1'b0;
      pend_w    <= 1'b0;
      iaddr_q   <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state     <= state_n;
      cur_type  <= type_n;
      cnt       <= cnt_n;
      cur_addr  <= addr_n;
      cur_wdata <= wd_n;
      ireq_q    <= ireadmiss;
      rreq_q    <= readmiss;
      wreq_q    <= writemiss;
      pend_i    <= pi_n;
      pend_d    <= pd_n;
      pend_w    <= pw_n;
      if (rise_i) iaddr_q <= iaddr;
      if (rise_d) raddr_q <= raddr;
      if (rise_w) begin
        waddr_q <= waddr;
        wdata_q <= wdata;
      end
    end
  end

  // Burst beats replace only the in-block offset, so the address wraps inside the block.
  always_comb begin
    busy        = (state != S_IDLE);
    mem_rd      = (state == S_BURST);
    mem_wr      = (state == S_WRITE);
    fill_valid  = (state == S_BURST);
    fill_target = (state == S_BURST) && (cur_type == T_D);
    fill_idx    = (state == S_BURST) ? cnt[IDX_W-1:0] : '0;
    fill_data   = (state == S_BURST) ? mem_rdata : '0;
    mem_wdata   = (state == S_WRITE) ? cur_wdata : '0;
    mem_addr    = '0;
    if (state == S_BURST)
      mem_addr = (cur_addr & ~BLK_MASK) | (ADDR_W'(cnt[IDX_W-1:0]) << 2);
    else if (state == S_WRITE)
      mem_addr = cur_addr;
    iReadReady  = (state == S_DONE) && (cur_type == T_I);
    ReadReady   = (state == S_DONE) && (cur_type == T_D);
    WriteReady  = (state == S_DONE) && (cur_type == T_W);
  end

endmodule

// File: tb/tb_mem_miss_responder.sv
// Bench for mem_miss_responder: transaction-schedule reference model compared every cycle,
// plus directed scenarios pinned to literal cycle expectations.
module tb_mem_miss_responder;

  localparam int L  = 4;
  localparam int B  = 4;
  localparam int NC = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireadmiss = 1'b0, readmiss = 1'b0, writemiss = 1'b0, abort = 1'b0;
  logic [31:0] iaddr = '0, raddr = '0, waddr = '0, wdata = '0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic        mem_rd, mem_wr, fill_valid, fill_target;
  logic [1:0]  fill_idx;
  logic        iReadReady, ReadReady, WriteReady, busy;

  mem_miss_responder #(.ADDR_W(32), .DATA_W(32), .BLOCK_WORDS(B), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .ireadmiss(ireadmiss), .iaddr(iaddr), .abort(abort),
    .readmiss(readmiss), .raddr(raddr),
    .writemiss(writemiss), .waddr(waddr), .wdata(wdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_target(fill_target), .fill_idx(fill_idx),
    .fill_data(fill_data),
    .iReadReady(iReadReady), .ReadReady(ReadReady), .WriteReady(WriteReady),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction
  assign mem_rdata = rd_fn(mem_addr);

  typedef struct packed {
    logic        rd, wr, fv, tgt;
    logic [1:0]  idx;
    logic [31:0] addr, wdata;
    logic        ir, rr, wrdy, busy;
  } exp_t;

  exp_t ex[NC];
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;

  // Model state: previous request levels, pending flags and the active transaction's extent.
  bit          pv_i, pv_d, pv_w, p_i, p_d, p_w, act;
  logic [31:0] a_i, a_d, a_w, wd_w;
  int          free_e, act_type, act_start, act_free;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, a, x);
    end
  endtask

  task automatic model_reset(input int k);
    pv_i = 0; pv_d = 0; pv_w = 0;
    p_i = 0; p_d = 0; p_w = 0;
    act = 0; free_e = 0;
    for (int j = k; j < NC; j++) ex[j] = '0;
  endtask

  // Lay out the whole transaction starting at edge e onto the per-cycle expectation table.
  task automatic start_txn(input int e, input int typ, input logic [31:0] a, input logic [31:0] d);
    int done_k;
    done_k = (typ == 2) ? e + L + 1 : e + L + B;
    for (int k = e; k <= done_k && k < NC; k++) ex[k].busy = 1'b1;
    if (typ == 2) begin
      if (e + L < NC) begin
        ex[e+L].wr = 1'b1; ex[e+L].addr = a; ex[e+L].wdata = d;
      end
      if (done_k < NC) ex[done_k].wrdy = 1'b1;
    end else begin
      for (int i = 0; i < B; i++) begin
        if (e + L + i < NC) begin
          ex[e+L+i].rd   = 1'b1;
          ex[e+L+i].fv   = 1'b1;
          ex[e+L+i].tgt  = (typ == 1);
          ex[e+L+i].idx  = 2'(i);
          ex[e+L+i].addr = (a & ~32'(B*4-1)) + 32'(4*i);
        end
      end
      if (done_k < NC) begin
        if (typ == 1) ex[done_k].rr = 1'b1;
        else          ex[done_k].ir = 1'b1;
      end
    end
    act = 1; act_type = typ; act_start = e; act_free = done_k + 1; free_e = done_k + 1;
  endtask

  task automatic model_step(input int e);
    bit ri, rdr, rw;
    ri  = ireadmiss && !pv_i && !abort;
    rdr = readmiss && !pv_d;
    rw  = writemiss && !pv_w;
    pv_i = ireadmiss; pv_d = readmiss; pv_w = writemiss;
    if (abort && act && act_type == 0 && e > act_start && e <= act_free) begin
      for (int k = e; k < act_free && k < NC; k++) ex[k] = '0;
      act = 0;
      free_e = e + 1;
    end
    if (ri)  begin p_i = 1; a_i = iaddr; end
    if (abort) p_i = 0;
    if (rdr) begin p_d = 1; a_d = raddr; end
    if (rw)  begin p_w = 1; a_w = waddr; wd_w = wdata; end
    if (e >= free_e) begin
      if (p_w)      begin p_w = 0; start_txn(e, 2, a_w, wd_w); end
      else if (p_d) begin p_d = 0; start_txn(e, 1, a_d, '0); end
      else if (p_i) begin p_i = 0; start_txn(e, 0, a_i, '0); end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) model_reset(cyc);
    else     model_step(cyc);
  end

  always @(negedge clk) begin
    if (cyc < NC) begin
      chk("mem_rd", 32'(mem_rd), 32'(ex[cyc].rd));
      chk("mem_wr", 32'(mem_wr), 32'(ex[cyc].wr));
      chk("fill_valid", 32'(fill_valid), 32'(ex[cyc].fv));
      chk("iReadReady", 32'(iReadReady), 32'(ex[cyc].ir));
      chk("ReadReady", 32'(ReadReady), 32'(ex[cyc].rr));
      chk("WriteReady", 32'(WriteReady), 32'(ex[cyc].wrdy));
      chk("busy", 32'(busy), 32'(ex[cyc].busy));
      if (ex[cyc].rd || ex[cyc].wr) chk("mem_addr", mem_addr, ex[cyc].addr);
      if (ex[cyc].wr) chk("mem_wdata", mem_wdata, ex[cyc].wdata);
      if (ex[cyc].fv) begin
        chk("fill_target", 32'(fill_target), 32'(ex[cyc].tgt));
        chk("fill_idx", 32'(fill_idx), 32'(ex[cyc].idx));
        chk("fill_data", fill_data, rd_fn(ex[cyc].addr));
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk);
    #1;
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_addr"}, mem_addr, 32'h0);
    chk({nm, "_strobes"}, {26'b0, mem_rd, mem_wr, fill_valid, iReadReady, ReadReady, WriteReady}, 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_data"}, fill_data | mem_wdata, 32'h0);
  endtask

  int e0, cnt_a, cnt_b;

  initial begin
    model_reset(0);
    tick(); tick();
    all_zero("reset");
    rst = 1'b0;
    tick(); tick();

    // Data read miss, wrapped burst from block base.
    readmiss = 1'b1; raddr = 32'h1000_0014; e0 = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      goto(e0 + 4 + i);
      chk("rd_beat_addr", mem_addr, 32'h1000_0010 + 32'(4 * i));
      chk("rd_beat_valid", {30'b0, fill_valid, fill_target}, 32'h3);
    end
    goto(e0 + 7); chk("rd_ready_early", 32'(ReadReady), 32'h0);
    goto(e0 + 8); chk("rd_ready", 32'(ReadReady), 32'h1);
    goto(e0 + 9); chk("rd_idle", {30'b0, ReadReady, busy}, 32'h0);
    readmiss = 1'b0;
    tick(); tick();

    // Write and instruction miss together: write wins.
    writemiss = 1'b1; waddr = 32'h20; wdata = 32'hDEAD_BEEF;
    ireadmiss = 1'b1; iaddr = 32'h400; e0 = cyc + 1;
    goto(e0 + 4);
    chk("wr_strobe", 32'(mem_wr), 32'h1);
    chk("wr_addr", mem_addr, 32'h20);
    chk("wr_data", mem_wdata, 32'hDEAD_BEEF);
    goto(e0 + 5); chk("wr_ready", 32'(WriteReady), 32'h1);
    writemiss = 1'b0;
    goto(e0 + 9); chk("i_wait", {31'b0, fill_valid}, 32'h0);
    goto(e0 + 10); chk("i_beat0", {fill_valid, fill_target, mem_addr[29:0]}, 32'h8000_0400);
    goto(e0 + 13); chk("i_beat3", mem_addr, 32'h40C);
    goto(e0 + 14); chk("i_ready", 32'(iReadReady), 32'h1);
    ireadmiss = 1'b0;
    tick(); tick();

    // Held request accepted once only.
    readmiss = 1'b1; raddr = 32'h0000_3008; e0 = cyc + 1;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 30; k++) begin
      goto(e0 + k);
      cnt_a += int'(ReadReady);
      cnt_b += int'(fill_valid);
    end
    chk("held_ready_count", 32'(cnt_a), 32'd1);
    chk("held_beat_count", 32'(cnt_b), 32'd4);
    readmiss = 1'b0;
    tick(); tick();

    // Abort during instruction burst.
    ireadmiss = 1'b1; iaddr = 32'h400; e0 = cyc + 1;
    goto(e0 + 5); abort = 1'b1;
    goto(e0 + 6); abort = 1'b0; ireadmiss = 1'b0;
    chk("abort_idle", {30'b0, fill_valid, busy}, 32'h0);
    cnt_a = 0;
    for (int k = 6; k < 20; k++) begin
      goto(e0 + k);
      cnt_a += int'(iReadReady);
    end
    chk("abort_no_ready", 32'(cnt_a), 32'd0);

    // Asynchronous reset in the middle of a data-read wait.
    readmiss = 1'b1; raddr = 32'h0000_0100; e0 = cyc + 1;
    goto(e0 + 2);
    #1 rst = 1'b1;
    model_reset(cyc);
    #1 all_zero("async_rst");
    readmiss = 1'b0;
    tick(); tick();
    rst = 1'b0;
    cnt_a = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      cnt_a += int'(iReadReady) + int'(ReadReady) + int'(WriteReady);
    end
    chk("post_rst_no_ready", 32'(cnt_a), 32'd0);

    // Data read beats instruction read; each serviced once.
    readmiss = 1'b1; raddr = 32'h100; ireadmiss = 1'b1; iaddr = 32'h204; e0 = cyc + 1;
    goto(e0 + 8); chk("dual_rd_ready", 32'(ReadReady), 32'h1);
    readmiss = 1'b0;
    goto(e0 + 13); chk("dual_i_beat0", mem_addr, 32'h200);
    goto(e0 + 17); chk("dual_i_ready", 32'(iReadReady), 32'h1);
    ireadmiss = 1'b0;
    tick(); tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(7) == 0) begin ireadmiss = ~ireadmiss; if (ireadmiss) iaddr = $urandom; end
      if ($urandom_range(7) == 0) begin readmiss = ~readmiss; if (readmiss) raddr = $urandom; end
      if ($urandom_range(9) == 0) begin
        writemiss = ~writemiss;
        if (writemiss) begin waddr = $urandom; wdata = $urandom; end
      end
      abort = ($urandom_range(15) == 0);
    end
    ireadmiss = 1'b0; readmiss = 1'b0; writemiss = 1'b0; abort = 1'b0;
    for (int n = 0; n < 60; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
